regin_loader: RTL and testbench
===============================

# regin_loader

Input-side counterpart of the NPU output register bank. Operators key bytes in on switches and commit them with toggle buttons, and the block packs four bytes into each 32-bit word of a DEPTH-entry buffer. When `s` is raised, it streams the buffer into the NPU as one word per clock with `valid`, then holds `done`.

## Interface
- `DEPTH`, default 11: number of 32-bit words in the buffer.
- `AW`, default 4: pointer width. Requires 2^AW > DEPTH.
- `clk`: input, 1 bit. Single clock; rising edge.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `sw`: input, 8 bits. Byte value to commit.
- `s_button`: input, 1 bit. Toggle-style button; each level change commits one byte.
- `p_button`: input, 1 bit. Toggle-style button; each level change advances to the next word.
- `s`: input, 1 bit. Level input; high requests streaming, low returns to loading.
- `out`: output, 32 bits. Streamed word. Byte 0 of a word is in [31:24], byte 3 is in [7:0].
- `valid`: output, 1 bit. `out` holds a buffer word this cycle.
- `done`: output, 1 bit. Stream is complete.
- `word_ptr`: output, AW bits. Current load word index.
- `byte_ptr`: output, 2 bits. Current load byte lane, 0..3.
- `echo`: output, 8 bits. Last committed byte, for the display.

## Operation
- Button events:
  - The block stores `sb_q` and `pb_q`, both reset to 0, and updates them every cycle in every state.
  - An event occurs when the sampled button value differs from its stored copy.
  - All inputs are synchronous to `clk`; the block has no synchronizer or debounce.
- State machine: LOAD (reset state), STREAM, DONE.
- LOAD:
  - On an s_button event: `mem[word_ptr]` lane `byte_ptr` gets `sw`; `echo` gets `sw`; `byte_ptr` increments, wrapping 3→0.
  - On a p_button event: `word_ptr` increments, wrapping DEPTH-1→0, and `byte_ptr` is cleared to 0.
  - If both events occur on the same edge, the byte is written into the old word first, then the word advances.
  - If `s` is sampled high, the state goes to STREAM. Button events on that same edge are ignored.
- STREAM:
  - The read pointer starts at 0.
  - Each cycle: `out` gets `mem[rd_ptr]`, `valid` goes to 1, and `rd_ptr` increments.
  - After word DEPTH-1 has been presented: `valid` and `out` go to 0, `done` goes to 1, and the state goes to DONE.
  - If `s` is sampled low during STREAM, the stream aborts: `valid` and `out` go to 0, `done` stays 0, and the state returns to LOAD.
- DONE:
  - `done` holds at 1 while `s` is high.
  - When `s` is sampled low, `done` goes to 0, the state returns to LOAD, and `word_ptr` and `byte_ptr` are cleared to 0.
  - Buffer contents are retained.
- Button events in STREAM and DONE are discarded; only the stored copies update.

## Timing
- Reset values: `out`=0, `valid`=0, `done`=0, `word_ptr`=0, `byte_ptr`=0, `echo`=0, all buffer words 0, `sb_q`=`pb_q`=0, state LOAD.
- Reset mid-stream: all of the above apply immediately (asynchronous).
- Byte commit: `echo` and the pointers update on the edge that samples the event.
- Stream latency: the edge that samples `s` high enters STREAM. The first valid word appears after the next edge.
- Stream length: exactly DEPTH consecutive `valid` cycles with no gaps.
- `done` rises on the edge after the last valid cycle.
- Minimum one edge between successive events on the same button; faster toggles are counted once per edge.

## Configuration
- `REGIN_AUTO_ADVANCE_EN`, defined:
  - An s_button event that writes lane 3 also increments `word_ptr` (wrapping at DEPTH) and sets `byte_ptr` to 0.
  - A p_button event on the same edge is ignored.
- `REGIN_AUTO_ADVANCE_EN`, undefined: after lane 3, `byte_ptr` wraps to 0 within the same word; only `p_button` advances the word.

## Test plan
- Reset, then hold `s`=0 for 5 cycles → all outputs 0 and `valid` never asserts.
- Load and stream (macro off):
  - Stimulus: `sw`=0xC0, then 0xA8, 0xA0, 0x00 with one s_button toggle each; one p_button toggle; raise `s`.
  - Response: the first streamed word is 0xC0A8A000 and the second is 0x00000000; `word_ptr` was 1 and `byte_ptr` was 0 before streaming.
  - Response: `valid` is high for exactly 11 cycles, then `done`=1.
- Simultaneous events: s_button and p_button toggle on the same edge with `sw`=0x55 at `word_ptr`=2, `byte_ptr`=1 → `mem[2]`[23:16]=0x55, `word_ptr`=3, `byte_ptr`=0.
- Wrap (macro off): commit 5 bytes 0x01..0x05 → word 0 = 0x05020304, `byte_ptr`=1.
- Wrap (macro on): commit 5 bytes 0x01..0x05 → word 0 = 0x01020304, `word_ptr`=1, word 1 [31:24]=0x05.
- Abort and reset:
  - Drop `s` after the 4th valid cycle → `valid`=0 on the next edge, `done` stays 0, state is LOAD.
  - Pulse `rst_n` low mid-stream → `out`=0, `valid`=0, and all buffer words read back 0 on the next stream.

Source files
------------

// File: rtl/regin_loader.sv
// regin_loader: operator byte loader that packs switch bytes into a DEPTH x 32-bit buffer and streams it to the NPU.
// Optional macro REGIN_AUTO_ADVANCE_EN: committing lane 3 also advances to the next word.
`default_nettype none

module regin_loader #(
    parameter int DEPTH = 11,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    sw,
    input  logic          s_button,
    input  logic          p_button,
    input  logic          s,
    output logic [31:0]   out,
    output logic          valid,
    output logic          done,
    output logic [AW-1:0] word_ptr,
    output logic [1:0]    byte_ptr,
    output logic [7:0]    echo
);

    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);
    localparam logic [AW-1:0] END_PTR   = AW'(DEPTH);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, next_state;

    logic          sb_q, pb_q;
    logic          sb_ev, pb_ev;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   mem [DEPTH];

    logic commit, advance, present, finish, clear;

    assign sb_ev = s_button ^ sb_q;
    assign pb_ev = p_button ^ pb_q;

    function automatic logic [AW-1:0] next_word(input logic [AW-1:0] w);
        return (w == LAST_WORD) ? '0 : w + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        commit     = 1'b0;
        advance    = 1'b0;
        present    = 1'b0;
        finish     = 1'b0;
        clear      = 1'b0;
        case (state)
            LOAD: begin
                // Raising s wins over any button event on the same edge.
                if (s) begin
                    next_state = STREAM;
                end else begin
                    commit  = sb_ev;
                    advance = pb_ev;
                end
            end
            STREAM: begin
                if (!s) begin
                    next_state = LOAD;
                end else if (rd_ptr == END_PTR) begin
                    next_state = DONE;
                    finish     = 1'b1;
                end else begin
                    present = 1'b1;
                end
            end
            DONE: begin
                if (!s) begin
                    next_state = LOAD;
                    clear      = 1'b1;
                end
            end
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q     <= 1'b0;
            pb_q     <= 1'b0;
            out      <= '0;
            valid    <= 1'b0;
            done     <= 1'b0;
            word_ptr <= '0;
            byte_ptr <= '0;
            echo     <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            sb_q <= s_button;
            pb_q <= p_button;

            // Lane 0 sits in the top byte, so the bit offset is 8*(3-lane).
            if (commit) begin
                mem[word_ptr][{~byte_ptr, 3'b000} +: 8] <= sw;
                echo                                    <= sw;
            end

`ifdef REGIN_AUTO_ADVANCE_EN
            if (commit) begin
                if (byte_ptr == 2'd3) begin
                    word_ptr <= next_word(word_ptr);
                    byte_ptr <= 2'd0;
                end else begin
                    byte_ptr <= byte_ptr + 2'd1;
                end
            end else if (advance) begin
                word_ptr <= next_word(word_ptr);
                byte_ptr <= 2'd0;
            end
`else
            if (advance) begin
                word_ptr <= next_word(word_ptr);
                byte_ptr <= 2'd0;
            end else if (commit) begin
                byte_ptr <= byte_ptr + 2'd1;
            end
`endif

            if (clear) begin
                word_ptr <= '0;
                byte_ptr <= '0;
            end

            if (present) begin
                out    <= mem[rd_ptr];
                valid  <= 1'b1;
                rd_ptr <= rd_ptr + 1'b1;
            end else begin
                out   <= '0;
                valid <= 1'b0;
                if (state != STREAM) begin
                    rd_ptr <= '0;
                end
            end

            done <= finish || (state == DONE && !clear);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regin_loader.sv
// Scoreboard bench for regin_loader: byte-level reference model, expected stream words queued, monitor pops on valid.
`default_nettype none

module tb_regin_loader;

    localparam int DEPTH = 11;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    sw;
    logic          s_button;
    logic          p_button;
    logic          s;
    logic [31:0]   out;
    logic          valid;
    logic          done;
    logic [AW-1:0] word_ptr;
    logic [1:0]    byte_ptr;
    logic [7:0]    echo;

    regin_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .s_button (s_button),
        .p_button (p_button),
        .s        (s),
        .out      (out),
        .valid    (valid),
        .done     (done),
        .word_ptr (word_ptr),
        .byte_ptr (byte_ptr),
        .echo     (echo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [31:0] expq[$];

    // Reference model: the buffer as bytes, lane 0 first.
    logic [7:0] mm [DEPTH][4];
    int         wp, bp;
    logic [7:0] m_echo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mword(input int w);
        return {mm[w][0], mm[w][1], mm[w][2], mm[w][3]};
    endfunction

    task automatic model_clear();
        for (int w = 0; w < DEPTH; w++)
            for (int l = 0; l < 4; l++) mm[w][l] = 8'h00;
        wp = 0; bp = 0; m_echo = 8'h00;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_valid: got out=%08h expected no valid word", out);
            end else begin
                check("stream_word", out, expq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cycle(input bit sev, input bit pev, input logic [7:0] v);
        sw = v;
        if (sev) s_button = ~s_button;
        if (pev) p_button = ~p_button;
        tick();
        if (sev) begin
            mm[wp][bp] = v;
            m_echo = v;
        end
`ifdef REGIN_AUTO_ADVANCE_EN
        if (sev) begin
            if (bp == 3) begin wp = (wp + 1) % DEPTH; bp = 0; end
            else bp = bp + 1;
        end else if (pev) begin
            wp = (wp + 1) % DEPTH; bp = 0;
        end
`else
        if (sev) bp = (bp + 1) % 4;
        if (pev) begin wp = (wp + 1) % DEPTH; bp = 0; end
`endif
        check("word_ptr", 32'(word_ptr), 32'(wp));
        check("byte_ptr", 32'(byte_ptr), 32'(bp));
        check("echo", 32'(echo), 32'(m_echo));
    endtask

    // Full stream; poke=1 throws button toggles that the block must discard.
    task automatic stream_full(input bit poke);
        for (int w = 0; w < DEPTH; w++) expq.push_back(mword(w));
        s = 1'b1;
        if (poke) s_button = ~s_button;
        tick();
        check("enter_valid", 32'(valid), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if (poke && i == 2) begin s_button = ~s_button; p_button = ~p_button; end
            tick();
            check("valid_run", 32'(valid), 32'd1);
            check("done_low_in_run", 32'(done), 32'd0);
        end
        tick();
        check("valid_end", 32'(valid), 32'd0);
        check("out_end", out, 32'd0);
        check("done_rise", 32'(done), 32'd1);
        if (poke) p_button = ~p_button;
        tick();
        check("done_hold", 32'(done), 32'd1);
        s = 1'b0;
        tick();
        check("done_clear", 32'(done), 32'd0);
        check("ptr_clear_w", 32'(word_ptr), 32'd0);
        check("ptr_clear_b", 32'(byte_ptr), 32'd0);
        check("queue_drained", 32'(expq.size()), 32'd0);
        wp = 0; bp = 0;
    endtask

    initial begin
        rst_n = 1'b0; sw = 8'h00; s_button = 1'b0; p_button = 1'b0; s = 1'b0;
        model_clear();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_out", out, 32'd0);
            check("rst_wp", 32'(word_ptr), 32'd0);
            check("rst_bp", 32'(byte_ptr), 32'd0);
            check("rst_echo", 32'(echo), 32'd0);
        end

        // Load 192.168.160.0, advance, stream.
        do_cycle(1, 0, 8'hC0);
        do_cycle(1, 0, 8'hA8);
        do_cycle(1, 0, 8'hA0);
        do_cycle(1, 0, 8'h00);
        do_cycle(0, 1, 8'h00);
        stream_full(0);

        // Simultaneous events at word 2, lane 1.
        do_cycle(0, 1, 8'h00);
        do_cycle(0, 1, 8'h00);
        do_cycle(1, 0, 8'h11);
        do_cycle(1, 1, 8'h55);
        stream_full(0);

        // Lane wrap from word 0.
        for (int i = 1; i <= 5; i++) do_cycle(1, 0, 8'(i));
        stream_full(1);

        // Randomized loading rounds, with holes between events.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 40; i++) begin
                do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                         8'($urandom));
            end
            stream_full(1'(r & 1));
        end

        // Abort after four valid cycles.
        do_cycle(1, 0, 8'h3C);
        for (int w = 0; w < 4; w++) expq.push_back(mword(w));
        s = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_valid_run", 32'(valid), 32'd1);
        end
        s = 1'b0;
        tick();
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", out, 32'd0);
        do_cycle(1, 0, 8'h9A);
        do_cycle(0, 1, 8'h00);
        check("abort_queue", 32'(expq.size()), 32'd0);

        // Asynchronous reset in mid-stream.
        for (int w = 0; w < 3; w++) expq.push_back(mword(w));
        s = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", out, 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_wp", 32'(word_ptr), 32'd0);
        check("mid_rst_echo", 32'(echo), 32'd0);
        s = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        stream_full(0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no end of test expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
